sync_fifo_prog: RTL

Single-clock, parametrised FIFO and the next generation of the team's FIFO family. It generalises data width and depth, and adds:
- a selectable first-word-fall-through (FWFT) read mode;
- programmable almost-full and almost-empty thresholds;
- a live fill-level count;
- optional sticky overflow/underflow error flags.

It sits between a producer and a consumer in the same clock domain, wherever the dual-clock FIFO's synchroniser cost is not justified.

---
 rtl/sync_fifo_pkg.sv | 22 ++
 rtl/sync_fifo_mem.sv | 62 ++++++
 rtl/sync_fifo_prog.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock FIFO family: depth and pointer-width
// sizing, plus the check that the almost-full/almost-empty thresholds are legal.
package sync_fifo_pkg;

  // Number of storage entries for a given address width.
  function automatic int unsigned fifo_depth(input int unsigned asize);
    return 32'd1 << asize;
  endfunction

  // Pointer/count width: one extra bit over the address so full and empty
  // can be told apart when the pointers wrap modulo 2*DEPTH.
  function automatic int unsigned ptr_width(input int unsigned asize);
    return $clog2(fifo_depth(asize)) + 1;
  endfunction

  // Thresholds must be ordered: 0 <= AEMPTY_TH < AFULL_TH <= DEPTH.
  function automatic bit thresholds_ok(input int aempty_th, input int afull_th,
                                       input int depth);
    return (aempty_th >= 0) && (aempty_th < afull_th) && (afull_th <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// One write port, one read port DSIZE x 2**ASIZE storage array.
// REG_OUT=1: read data is registered and loads on re (block-RAM style).
// REG_OUT=0: read data follows raddr combinationally (first-word-fall-through).
// Storage contents are never cleared; only the output register resets.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE   = 8,
  parameter int ASIZE   = 8,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = int'(fifo_depth(ASIZE));

  logic [DSIZE-1:0] mem_q [0:DEPTH-1];

  // Write port: the top level only asserts we for accepted writes.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  if (REG_OUT) begin : g_reg_read
    logic [DSIZE-1:0] rdata_q;
    logic [DSIZE-1:0] rdata_d;

    // Output register loads only on an accepted read, otherwise holds.
    always_comb begin
      rdata_d = rdata_q;
      if (re) begin
        rdata_d = mem_q[raddr];
      end
    end

    // Output register with synchronous clear.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign rdata = rdata_q;
  end else begin : g_async_read
    // Read enable and reset have no meaning for a combinational read.
    logic unused_ctrl;
    assign unused_ctrl = rst ^ re;
    assign rdata       = mem_q[raddr];
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock parametrised FIFO with selectable FWFT read mode, programmable
// almost-full/almost-empty thresholds, live fill count and, when the macro
// SYNC_FIFO_ERR_EN is defined, sticky overflow/underflow flags (tied to 0 otherwise).
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 8,
  parameter bit FWFT      = 1'b0,
  parameter int AFULL_TH  = 2**ASIZE - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = int'(fifo_depth(ASIZE));
  localparam int PW    = int'(ptr_width(ASIZE));

  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);
  localparam logic [PW-1:0] ONE_C    = PW'(1);

  if (!thresholds_ok(AEMPTY_TH, AFULL_TH, DEPTH)) begin : g_bad_thresholds
    $error("sync_fifo_prog: need 0 <= AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic          wfull_q, wfull_d, rempty_q, rempty_d;
  logic          walmost_full_q, walmost_full_d, ralmost_empty_q, ralmost_empty_d;
  logic          wr_acc, rd_acc;

  // Accept/reject requests, advance pointers and count, and derive the
  // registered flags from the count the FIFO will hold after this edge.
  always_comb begin
    wr_acc  = winc && !wfull_q;
    rd_acc  = rinc && !rempty_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) begin
      wptr_d = wptr_q + ONE_C;
    end
    if (rd_acc) begin
      rptr_d = rptr_q + ONE_C;
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + ONE_C;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - ONE_C;
    end
    wfull_d         = (count_d == DEPTH_C);
    rempty_d        = (count_d == '0);
    walmost_full_d  = (count_d >= AFULL_C);
    ralmost_empty_d = (count_d <= AEMPTY_C);
  end

  // Pointer, count and flag state; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      wfull_q         <= 1'b0;
      rempty_q        <= 1'b1;
      walmost_full_q  <= (AFULL_TH == 0);
      ralmost_empty_q <= 1'b1;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      count_q         <= count_d;
      wfull_q         <= wfull_d;
      rempty_q        <= rempty_d;
      walmost_full_q  <= walmost_full_d;
      ralmost_empty_q <= ralmost_empty_d;
    end
  end

  sync_fifo_mem #(
    .DSIZE   (DSIZE),
    .ASIZE   (ASIZE),
    .REG_OUT (!FWFT)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc && !rst),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (wdata),
    .re    (rd_acc && !rst),
    .raddr (rptr_q[ASIZE-1:0]),
    .rdata (rdata)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  // Sticky error flags: any request made against a full/empty FIFO.
  always_comb begin
    overflow_d  = overflow_q  || (winc && wfull_q);
    underflow_d = underflow_q || (rinc && rempty_q);
  end

  // Error flags clear only on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = walmost_full_q;
  assign ralmost_empty = ralmost_empty_q;
  assign count         = count_q;

endmodule
